output_channel_sequencer: RTL

Parametrised successor to the single-channel output mux. It sits between the wavelet filter bank's truncated outputs and the chip output pins, and presents one filter channel per accepted sample. Channel choice is either manual (select port) or automatic round-robin scan with a programmable dwell. Each output sample carries a channel tag, a valid strobe and a frame-start marker.

---
 rtl/output_channel_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/output_channel_sequencer.sv
// Output channel sequencer: registers one filter-bank channel per accepted sample,
// chosen manually or by a round-robin scan with programmable dwell.
module output_channel_sequencer #(
   parameter int NUM_FILTERS    = 8,
   parameter int SUM_TRUNCATION = 8,
   parameter int DWELL_WIDTH    = 8,
   localparam int CH_W          = $clog2(NUM_FILTERS)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_FILTERS*SUM_TRUNCATION-1:0] i_truncated_wavelet_out,
   input  logic                                  i_sample_valid,
   input  logic [1:0]                            i_mode,
   input  logic [7:0]                            i_select_output_channel,
   input  logic [DWELL_WIDTH-1:0]                i_dwell,
   output logic [SUM_TRUNCATION-1:0]             o_multiplexed_wavelet_out,
   output logic [CH_W-1:0]                       o_channel,
   output logic                                  o_valid,
   output logic                                  o_frame_start
);

   localparam logic [1:0] MODE_MANUAL = 2'b00;
   localparam logic [1:0] MODE_SCAN   = 2'b01;

   function automatic logic [CH_W-1:0] clamp_channel(input logic [7:0] sel);
      if (32'(sel) < NUM_FILTERS) begin
         return CH_W'(sel);
      end
      return '0;
   endfunction

   function automatic logic [SUM_TRUNCATION-1:0] pick_slice(
      input logic [NUM_FILTERS*SUM_TRUNCATION-1:0] bus,
      input logic [CH_W-1:0]                       ch
   );
      return bus[ch*SUM_TRUNCATION +: SUM_TRUNCATION];
   endfunction

   // A dwell of 0 behaves as 1; >= lets a lowered dwell take effect without wrapping.
   function automatic logic dwell_done(
      input logic [DWELL_WIDTH-1:0] cnt,
      input logic [DWELL_WIDTH-1:0] dwell
   );
      logic [DWELL_WIDTH:0] w_d;
      w_d = (dwell == '0) ? (DWELL_WIDTH+1)'(1) : {1'b0, dwell};
      return ({1'b0, cnt} + (DWELL_WIDTH+1)'(1)) >= w_d;
   endfunction

   function automatic logic [CH_W-1:0] next_channel(input logic [CH_W-1:0] ptr);
      if (ptr == CH_W'(NUM_FILTERS - 1)) begin
         return '0;
      end
      return ptr + CH_W'(1);
   endfunction

   logic [CH_W-1:0]           r_scan_ch;
   logic [DWELL_WIDTH-1:0]    r_dwell_cnt;
   logic [1:0]                r_prev_mode;
   logic [SUM_TRUNCATION-1:0] r_data_p1;
   logic [CH_W-1:0]           r_ch_p1;
   logic                      r_vld_p1;
   logic                      r_fs_p1;

   logic                      w_is_manual_p0;
   logic                      w_is_scan_p0;
   logic                      w_accept_p0;
   logic                      w_scan_entry_p0;
   logic [CH_W-1:0]           w_ptr_p0;
   logic [DWELL_WIDTH-1:0]    w_cnt_p0;
   logic [CH_W-1:0]           w_ch_p0;
   logic                      w_fs_p0;
   logic                      w_advance_p0;
   logic [CH_W-1:0]           w_scan_ch_nxt;
   logic [DWELL_WIDTH-1:0]    w_dwell_cnt_nxt;

   // Stage p0: channel selection and scan bookkeeping
   always_comb begin
      w_is_manual_p0  = (i_mode == MODE_MANUAL);
      w_is_scan_p0    = (i_mode == MODE_SCAN);
      w_accept_p0     = i_sample_valid && (w_is_manual_p0 || w_is_scan_p0);
      w_scan_entry_p0 = (r_prev_mode != MODE_SCAN);

      w_ptr_p0 = w_scan_entry_p0 ? '0 : r_scan_ch;
      w_cnt_p0 = w_scan_entry_p0 ? '0 : r_dwell_cnt;

      w_ch_p0 = w_is_scan_p0 ? w_ptr_p0 : clamp_channel(i_select_output_channel);
      w_fs_p0 = w_is_scan_p0 && (w_ptr_p0 == '0) && (w_cnt_p0 == '0);

      w_advance_p0 = dwell_done(w_cnt_p0, i_dwell);

      w_scan_ch_nxt   = r_scan_ch;
      w_dwell_cnt_nxt = r_dwell_cnt;
      if (w_is_scan_p0) begin
         if (i_sample_valid) begin
            if (w_advance_p0) begin
               w_scan_ch_nxt   = next_channel(w_ptr_p0);
               w_dwell_cnt_nxt = '0;
            end else begin
               w_scan_ch_nxt   = w_ptr_p0;
               w_dwell_cnt_nxt = w_cnt_p0 + DWELL_WIDTH'(1);
            end
         end else if (w_scan_entry_p0) begin
            w_scan_ch_nxt   = '0;
            w_dwell_cnt_nxt = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_scan_ch   <= '0;
         r_dwell_cnt <= '0;
         r_prev_mode <= MODE_MANUAL;
      end else begin
         r_scan_ch   <= w_scan_ch_nxt;
         r_dwell_cnt <= w_dwell_cnt_nxt;
         r_prev_mode <= i_mode;
      end
   end

   // Stage p1: registered output sample, tag and strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data_p1 <= '0;
         r_ch_p1   <= '0;
         r_vld_p1  <= 1'b0;
         r_fs_p1   <= 1'b0;
      end else begin
         r_vld_p1 <= w_accept_p0;
         r_fs_p1  <= w_accept_p0 && w_fs_p0;
         if (w_accept_p0) begin
            r_data_p1 <= pick_slice(i_truncated_wavelet_out, w_ch_p0);
            r_ch_p1   <= w_ch_p0;
         end
      end
   end

   assign o_multiplexed_wavelet_out = r_data_p1;
   assign o_channel                 = r_ch_p1;
   assign o_valid                   = r_vld_p1;
   assign o_frame_start             = r_fs_p1;

endmodule
